keypad_scan_db: RTL and testbench
=================================

KEYPAD_SCAN_DB -- requirements
Module: keypad_scan_db

Interface
REQ-001 The block SHALL have parameter COLS, default 4, number of driven column lines (2..8).
REQ-002 The block SHALL have parameter ROWS, default 4, number of sensed row lines (2..8).
REQ-003 The block SHALL have parameter SCAN_DIV, default 100, clk cycles each column is driven (>=2).
REQ-004 The block SHALL have parameter DEBOUNCE, default 3, consecutive identical scan frames required to accept a press or a release (1..15).
REQ-005 The block SHALL define localparam CW = $clog2(ROWS*COLS), the key code width.
REQ-006 The block SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port col_n, output, COLS, active-low one-cold column drive.
REQ-009 The block SHALL have port row_n, input, ROWS, active-low row sense (0 = key closed on driven column).
REQ-010 The block SHALL have port key_code, output, CW, accepted key = row*COLS + col.
REQ-011 The block SHALL have port key_valid, output, 1, level high while key_code holds an unacknowledged key.
REQ-012 The block SHALL have port key_ack, input, 1, consumer acknowledge, one-cycle pulse.
REQ-013 The block SHALL have port key_held, output, 1, high while the accepted key remains physically pressed.
REQ-014 The block SHALL have port overrun, output, 1, sticky flag: a key was accepted while key_valid was high without key_ack.

Function
REQ-015 Scanning SHALL drive column c low for SCAN_DIV cycles, then advance c by 1, wrapping COLS-1 -> 0; one full pass is a frame of COLS*SCAN_DIV cycles.
REQ-016 row_n SHALL be sampled only in the last cycle of each column dwell, for settling.
REQ-017 At frame end the block SHALL classify the frame as NONE (no closed contact), ONE(code) (exactly one contact), or MULTI (two or more contacts); ONE reports the code.
REQ-018 The FSM SHALL have states IDLE, DEBOUNCE, PRESSED, RELEASE, evaluated only at frame ends.
REQ-019 In IDLE, ONE(k) SHALL go to DEBOUNCE with candidate k and count 1; NONE or MULTI SHALL stay in IDLE.
REQ-020 In DEBOUNCE, ONE(k) equal to the candidate SHALL increment count; when count reaches DEBOUNCE the FSM SHALL go to PRESSED and accept k; ONE of a different code SHALL restart with the new candidate and count 1; NONE or MULTI SHALL return to IDLE.
REQ-021 With DEBOUNCE=1, IDLE SHALL go directly to PRESSED on the first ONE frame.
REQ-022 In PRESSED, key_held SHALL be 1; a NONE frame SHALL go to RELEASE with count 1; ONE or MULTI frames SHALL stay, with no new acceptance.
REQ-023 In RELEASE, DEBOUNCE consecutive NONE frames SHALL go to IDLE and clear key_held; any ONE or MULTI frame SHALL return to PRESSED.
REQ-024 On acceptance, key_valid SHALL rise and key_code load in the cycle after the accepting frame end: latency one cycle from the last sample.
REQ-025 key_ack with key_valid=1 SHALL clear key_valid next cycle and clear overrun; key_ack with key_valid=0 SHALL be ignored.
REQ-026 An acceptance while key_valid=1 and no key_ack SHALL keep the old key_code and set overrun.
REQ-027 An acceptance in the same cycle as key_ack SHALL load the new code, keep key_valid=1, and clear overrun.
REQ-028 key_code SHALL stay stable while key_valid=1 except per REQ-027.

Reset
REQ-029 rst SHALL immediately force: col_n = all ones except bit 0 low, column/dwell counters 0, FSM IDLE, key_code 0, key_valid 0, key_held 0, overrun 0.
REQ-030 A reset mid-debounce or mid-frame SHALL discard the partial frame and the candidate; scanning SHALL restart at column 0 on the first edge after release.

Structure
REQ-031 The FSM state encoding, the frame-result encoding (NONE/ONE/MULTI) and the CW width function SHALL live in shared package/header keypad_pkg.
REQ-032 The column ring and dwell counter SHALL be sub-module keypad_col_scanner, outputting col_n, column index and a sample strobe.

Verification (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=3; frame = 16 cycles)
REQ-033 Reset: assert rst mid-scan -> col_n=4'b1110, key_valid=0, key_code=0, overrun=0; after release col_n steps 1110,1101,1011,0111 every 4 cycles.
REQ-034 Clean press: row_n=4'b1101 whenever col_n=4'b1011 for 5 frames -> key_valid rises 1 cycle after 3rd frame end, key_code=6, key_held=1; key_ack -> key_valid=0; release -> key_held=0 after 3 NONE frames.
REQ-035 Bounce: key 6 for 2 frames, 1 NONE frame, then 3 frames -> exactly one key_valid rise, after the final 3rd frame.
REQ-036 Multi-key: keys 0 and 5 closed for 5 frames -> key_valid stays 0, FSM stays IDLE.
REQ-037 Overrun: accept key 6, release, accept key 9 without key_ack -> key_code=6, overrun=1; key_ack -> key_valid=0, overrun=0.
REQ-038 Simultaneous: key_ack in the acceptance cycle of key 9 -> key_valid stays 1, key_code=9, overrun=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states, frame classes, code width.
package keypad_pkg;

    // Debounce counter width; DEBOUNCE is limited to 1..15
    localparam int unsigned DB_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_kind_e;

    // Key code width for a rows x cols matrix
    function automatic int unsigned keypad_cw(input int unsigned rows, input int unsigned cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column ring with dwell counter; emits the one-cold column drive, the driven
// column index, a strobe in the last dwell cycle and a frame-end strobe.
module keypad_col_scanner #(
    parameter  int unsigned COLS     = 4,
    parameter  int unsigned SCAN_DIV = 100,
    localparam int unsigned CIW      = $clog2(COLS),
    localparam int unsigned DW       = $clog2(SCAN_DIV)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [COLS-1:0] col_n_o,
    output logic [CIW-1:0]  col_idx_o,
    output logic            sample_o,
    output logic            frame_end_o
);

    logic [DW-1:0]   dwell_q, dwell_d;
    logic [CIW-1:0]  col_q, col_d;
    logic [COLS-1:0] col_n_q, col_n_d;
    logic            sample_q, sample_d;
    logic            frame_end_q, frame_end_d;
    logic            last_c;

    // Next dwell/column; strobes are precomputed so they are registered
    always_comb begin
        last_c  = (dwell_q == DW'(SCAN_DIV - 1));
        dwell_d = dwell_q + DW'(1);
        col_d   = col_q;
        if (last_c) begin
            dwell_d = '0;
            col_d   = (col_q == CIW'(COLS - 1)) ? '0 : col_q + CIW'(1);
        end
        col_n_d     = ~(COLS'(1) << col_d);
        sample_d    = (dwell_d == DW'(SCAN_DIV - 1));
        frame_end_d = sample_d && (col_d == CIW'(COLS - 1));
    end

    // Scan state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dwell_q     <= '0;
            col_q       <= '0;
            col_n_q     <= ~COLS'(1);
            sample_q    <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            col_n_q     <= col_n_d;
            sample_q    <= sample_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign col_n_o     = col_n_q;
    assign col_idx_o   = col_q;
    assign sample_o    = sample_q;
    assign frame_end_o = frame_end_q;

endmodule

// File: rtl/keypad_scan_db.sv
// Matrix keypad scanner with frame-based debounce and a one-deep key buffer.
module keypad_scan_db
    import keypad_pkg::*;
#(
    parameter  int unsigned COLS     = 4,
    parameter  int unsigned ROWS     = 4,
    parameter  int unsigned SCAN_DIV = 100,
    parameter  int unsigned DEBOUNCE = 3,
    localparam int unsigned CW       = keypad_cw(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [COLS-1:0] col_n,
    input  logic [ROWS-1:0] row_n,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ack,
    output logic            key_held,
    output logic            overrun
);

    localparam int unsigned CIW   = $clog2(COLS);
    localparam int unsigned RIW   = $clog2(ROWS);
    localparam int unsigned CNT_W = DB_CNT_W;

    logic [CIW-1:0]   col_idx;
    logic             sample;
    logic             frame_end;

    logic [3:0]       closed_c;
    logic [RIW-1:0]   first_row_c;
    logic [CW-1:0]    sample_code_c;
    logic [1:0]       merged_cnt_c;
    logic [CW-1:0]    merged_code_c;
    frame_kind_e      frame_kind_c;

    logic [1:0]       acc_cnt_q;
    logic [CW-1:0]    acc_code_q;

    kp_state_e        state_q;
    logic [CW-1:0]    cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             accept_c;
    logic             ack_ok_c;

    logic [CW-1:0]    key_code_q;
    logic             key_valid_q;
    logic             key_held_q;
    logic             overrun_q;

    keypad_col_scanner #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk_i       (clk),
        .rst_i       (rst),
        .col_n_o     (col_n),
        .col_idx_o   (col_idx),
        .sample_o    (sample),
        .frame_end_o (frame_end)
    );

    // Decode the current row sample and merge it into the running frame result
    always_comb begin
        closed_c    = 4'd0;
        first_row_c = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (!row_n[r]) begin
                if (closed_c == 4'd0) begin
                    first_row_c = RIW'(r);
                end
                closed_c = closed_c + 4'd1;
            end
        end
        sample_code_c = CW'(32'(first_row_c) * COLS + 32'(col_idx));

        merged_cnt_c  = acc_cnt_q;
        merged_code_c = acc_code_q;
        if (closed_c >= 4'd2) begin
            merged_cnt_c = 2'd2;
        end else if (closed_c == 4'd1) begin
            if (acc_cnt_q == 2'd0) begin
                merged_cnt_c  = 2'd1;
                merged_code_c = sample_code_c;
            end else begin
                merged_cnt_c = 2'd2;
            end
        end

        frame_kind_c = FR_NONE;
        if (merged_cnt_c == 2'd1) begin
            frame_kind_c = FR_ONE;
        end else if (merged_cnt_c == 2'd2) begin
            frame_kind_c = FR_MULTI;
        end
    end

    // Contact accumulator, cleared at each frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
        end else if (sample) begin
            if (frame_end) begin
                acc_cnt_q  <= 2'd0;
                acc_code_q <= '0;
            end else begin
                acc_cnt_q  <= merged_cnt_c;
                acc_code_q <= merged_code_c;
            end
        end
    end

    // Acceptance fires on the frame end that completes the debounce run
    always_comb begin
        cnt_inc_c = cnt_q + CNT_W'(1);
        accept_c  = 1'b0;
        if (frame_end && (frame_kind_c == FR_ONE)) begin
            if ((state_q == ST_IDLE) && (DEBOUNCE == 1)) begin
                accept_c = 1'b1;
            end else if ((state_q == ST_DEBOUNCE) && (merged_code_c == cand_q) &&
                         (cnt_inc_c == CNT_W'(DEBOUNCE))) begin
                accept_c = 1'b1;
            end
        end
        ack_ok_c = key_ack && key_valid_q;
    end

    // Debounce FSM, stepped only at frame ends; owns key_held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            key_held_q <= 1'b0;
        end else if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_kind_c == FR_ONE) begin
                        if (DEBOUNCE == 1) begin
                            state_q    <= ST_PRESSED;
                            key_held_q <= 1'b1;
                        end else begin
                            state_q <= ST_DEBOUNCE;
                            cand_q  <= merged_code_c;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_kind_c == FR_ONE) begin
                        if (merged_code_c == cand_q) begin
                            if (cnt_inc_c == CNT_W'(DEBOUNCE)) begin
                                state_q    <= ST_PRESSED;
                                key_held_q <= 1'b1;
                                cnt_q      <= '0;
                            end else begin
                                cnt_q <= cnt_inc_c;
                            end
                        end else begin
                            cand_q <= merged_code_c;
                            cnt_q  <= CNT_W'(1);
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_kind_c == FR_NONE) begin
                        if (DEBOUNCE == 1) begin
                            state_q    <= ST_IDLE;
                            key_held_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            state_q <= ST_RELEASE;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (frame_kind_c == FR_NONE) begin
                        if (cnt_inc_c == CNT_W'(DEBOUNCE)) begin
                            state_q    <= ST_IDLE;
                            key_held_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_inc_c;
                        end
                    end else begin
                        state_q <= ST_PRESSED;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // One-deep key buffer with acknowledge and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (accept_c) begin
            if (key_valid_q && !key_ack) begin
                overrun_q <= 1'b1;
            end else begin
                key_code_q  <= merged_code_c;
                key_valid_q <= 1'b1;
                if (ack_ok_c) begin
                    overrun_q <= 1'b0;
                end
            end
        end else if (ack_ok_c) begin
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_db.sv
// Randomized and directed bench for keypad_scan_db against a frame-level model.
module tb_keypad_scan_db;

    localparam int unsigned COLS     = 4;
    localparam int unsigned ROWS     = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DB       = 3;
    localparam int unsigned FRAME    = COLS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        overrun;

    logic [15:0] pressed;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    bit          m_valid, m_over, m_held;
    logic [3:0]  m_code;
    int          run_key, run_len, none_len;

    always #5 clk = ~clk;

    keypad_scan_db #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    // Physical matrix: a pressed key pulls its row low when its column is driven
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 0; m_over = 0; m_held = 0; m_code = 4'd0;
        run_key = -1; run_len = 0; none_len = 0;
    endtask

    // Frame-level reference: press needs DB identical single-key frames,
    // release needs DB empty frames; one-deep buffer with overrun
    task automatic model_frame(input logic [15:0] keys, input bit ack_end);
        int n;
        int k;
        bit acc;
        n   = $countones(keys);
        k   = -1;
        acc = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) k = i;
        if (!m_held) begin
            if (n == 1) begin
                if (run_len > 0 && k == run_key) run_len++;
                else begin run_key = k; run_len = 1; end
                if (run_len >= int'(DB)) begin
                    acc = 1; m_held = 1; run_len = 0; none_len = 0;
                end
            end else begin
                run_len = 0;
            end
        end else begin
            if (n == 0) begin
                none_len++;
                if (none_len >= int'(DB)) begin m_held = 0; none_len = 0; end
            end else begin
                none_len = 0;
            end
        end
        if (acc) begin
            if (m_valid && !ack_end) m_over = 1;
            else begin
                m_code = 4'(k); m_valid = 1;
                if (ack_end) m_over = 0;
            end
        end else if (ack_end && m_valid) begin
            m_valid = 0; m_over = 0;
        end
    endtask

    // One full scan frame with optional ack in the first or the last cycle
    task automatic run_frame(input logic [15:0] keys, input bit ack_early,
                             input bit ack_end, input bit walk);
        pressed = keys;
        if (ack_early && m_valid) begin m_valid = 0; m_over = 0; end
        for (int cyc = 1; cyc <= int'(FRAME); cyc++) begin
            if ((cyc == 1 && ack_early) || (cyc == int'(FRAME) && ack_end)) key_ack = 1'b1;
            @(posedge clk);
            #1;
            key_ack = 1'b0;
            if (walk) chk("col_walk", 32'(col_n), 32'(~(4'b0001 << ((cyc / 4) % 4)) & 4'hF));
            if (cyc == int'(FRAME) - 1) chk("valid_pre_end", 32'(key_valid), 32'(m_valid));
        end
        model_frame(keys, ack_end);
        chk("key_valid", 32'(key_valid), 32'(m_valid));
        chk("key_code",  32'(key_code),  32'(m_code));
        chk("overrun",   32'(overrun),   32'(m_over));
        chk("key_held",  32'(key_held),  32'(m_held));
    endtask

    // Reset after pre_cycles of the current frame, then a walk-checked empty frame
    task automatic do_reset(input int pre_cycles);
        repeat (pre_cycles) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_col_n",  32'(col_n),     32'(4'b1110));
        chk("rst_valid",  32'(key_valid), 32'd0);
        chk("rst_code",   32'(key_code),  32'd0);
        chk("rst_over",   32'(overrun),   32'd0);
        chk("rst_held",   32'(key_held),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run_frame(16'h0000, 0, 0, 1);
    endtask

    task automatic frames(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) run_frame(keys, 0, 0, 0);
    endtask

    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K05 = 16'h0021;

    initial begin
        rst     = 1'b1;
        key_ack = 1'b0;
        pressed = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(16'h0000, 0, 0, 1);

        // mid-scan reset
        do_reset(7);

        // clean press of key 6, ack, release
        frames(K6, 3);
        chk("press_code6", 32'(key_code), 32'd6);
        frames(K6, 1);
        run_frame(K6, 1, 0, 0);
        chk("ack_clears", 32'(key_valid), 32'd0);
        frames(16'h0000, 2);
        chk("held_mid_release", 32'(key_held), 32'd1);
        frames(16'h0000, 1);
        chk("held_released", 32'(key_held), 32'd0);

        // bounce: 2 frames, gap, 3 frames -> one acceptance
        frames(K6, 2);
        frames(16'h0000, 1);
        frames(K6, 2);
        chk("bounce_no_early", 32'(key_valid), 32'd0);
        frames(K6, 1);
        chk("bounce_accept", 32'(key_valid), 32'd1);
        frames(16'h0000, 3);
        run_frame(16'h0000, 1, 0, 0);

        // two keys closed: never accepted
        frames(K05, 5);
        chk("multi_valid", 32'(key_valid), 32'd0);
        frames(16'h0000, 1);

        // overrun: 6 accepted, 9 accepted without ack
        frames(K6, 3);
        frames(16'h0000, 3);
        frames(K9, 3);
        chk("ovr_code", 32'(key_code), 32'd6);
        chk("ovr_flag", 32'(overrun), 32'd1);
        run_frame(16'h0000, 1, 0, 0);
        chk("ovr_ack_over", 32'(overrun), 32'd0);
        frames(16'h0000, 2);

        // ack coinciding with acceptance of 9
        frames(K6, 3);
        frames(16'h0000, 3);
        frames(K9, 2);
        run_frame(K9, 0, 1, 0);
        chk("simul_valid", 32'(key_valid), 32'd1);
        chk("simul_code",  32'(key_code),  32'd9);
        chk("simul_over",  32'(overrun),   32'd0);
        frames(16'h0000, 3);
        run_frame(16'h0000, 1, 0, 0);

        // random runs of patterns, random acks, one random reset
        for (int it = 0; it < 50; it++) begin
            logic [15:0] keys;
            int sel;
            int len;
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 4));
            if (sel < 2)      keys = 16'h0000;
            else if (sel < 8) keys = 16'h0001 << $urandom_range(0, 15);
            else              keys = (16'h0001 << $urandom_range(0, 7)) | (16'h0100 << $urandom_range(0, 7));
            if (it == 25) do_reset(int'($urandom_range(2, 14)));
            for (int j = 0; j < len; j++) begin
                run_frame(keys, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
